// File: rtl/tdc_result_fifo_if.sv
// tdc_result_fifo_if: capture/readout signal bundle for the TDC result FIFO
//   slave  : the FIFO (takes done/TDC/ready/clear, drives head word and status)
//   master : the environment (TDC core + readout consumer)
interface tdc_result_fifo_if #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 16,
    parameter int SEQ_W  = 8,
    parameter int DROP_W = 16
);
    logic                    iDone;
    logic [DATA_W-1:0]       iTDC;
    logic [SEQ_W+DATA_W-1:0] oData;
    logic                    oValid;
    logic                    iReady;
    logic [$clog2(DEPTH):0]  oLevel;
    logic                    oFull;
    logic [DROP_W-1:0]       oDropCnt;
    logic                    oOverflow;
    logic                    iClrStat;
    modport master (output iDone, iTDC, iReady, iClrStat,
                    input  oData, oValid, oLevel, oFull, oDropCnt, oOverflow);
    modport slave  (input  iDone, iTDC, iReady, iClrStat,
                    output oData, oValid, oLevel, oFull, oDropCnt, oOverflow);
endinterface

// File: rtl/tdc_result_fifo.sv
// tdc_result_fifo: tags each TDC conversion with a wrapping sequence number and buffers it in an FWFT FIFO
//   iClk, iRst : clock, asynchronous active-high reset
//   bus        : slave side of tdc_result_fifo_if (capture in, valid/ready stream out, drop stats)
module tdc_result_fifo #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 16,
    parameter int SEQ_W  = 8,
    parameter int DROP_W = 16
) (
    input logic iClk,
    input logic iRst,
    tdc_result_fifo_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int WW = SEQ_W + DATA_W;
    logic [WW-1:0]     mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [LW-1:0]     level_q, level_d;
    logic [SEQ_W-1:0]  seq_q;
    logic [DROP_W-1:0] drop_q, drop_d;
    logic              ovf_q, ovf_d, done_q;
    logic [WW-1:0]     data_q, head_d, word;
    logic              cap, full, push, drop, pop;
    always_comb begin
        cap     = bus.iDone & ~done_q;
        full    = level_q == LW'(DEPTH);
        push    = cap & ~full;
        drop    = cap & full;
        pop     = (level_q != '0) & bus.iReady;
        word    = {seq_q, bus.iTDC};
        level_d = level_q + LW'(push) - LW'(pop);
        // Head is kept in a register: it follows the next stored entry on a pop, takes the
        // incoming word when that word becomes the only entry, and otherwise holds (last head).
        head_d  = (pop & (level_q > LW'(1))) ? mem_q[rd_ptr_q + AW'(1)] :
                  (push & (level_q == LW'(pop))) ? word : data_q;
        // A drop in the same cycle as a clear leaves a count of one.
        drop_d  = drop ? (bus.iClrStat ? DROP_W'(1) : (&drop_q ? drop_q : drop_q + DROP_W'(1))) :
                  (bus.iClrStat ? '0 : drop_q);
        ovf_d   = drop | (ovf_q & ~bus.iClrStat);
    end
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            done_q   <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            seq_q    <= '0;
            drop_q   <= '0;
            ovf_q    <= 1'b0;
            data_q   <= '0;
        end else begin
            done_q   <= bus.iDone;
            wr_ptr_q <= push ? wr_ptr_q + AW'(1) : wr_ptr_q;
            rd_ptr_q <= pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
            level_q  <= level_d;
            seq_q    <= cap ? seq_q + SEQ_W'(1) : seq_q;
            drop_q   <= drop_d;
            ovf_q    <= ovf_d;
            data_q   <= head_d;
        end
    end
    always_ff @(posedge iClk) begin
        if (push) mem_q[wr_ptr_q] <= word;
    end
    assign bus.oData     = data_q;
    assign bus.oValid    = level_q != '0;
    assign bus.oLevel    = level_q;
    assign bus.oFull     = full;
    assign bus.oDropCnt  = drop_q;
    assign bus.oOverflow = ovf_q;
endmodule

// File: tb/tb_tdc_result_fifo.sv
// tb_tdc_result_fifo: randomized bench for tdc_result_fifo against a queue-based reference model
module tb_tdc_result_fifo;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int errors = 0;
    logic [23:0] m_q [$];
    logic [23:0] m_head;
    logic [7:0]  m_seq;
    logic [15:0] m_drop;
    logic        m_ovf, m_prev;
    tdc_result_fifo_if #(.DATA_W(16), .DEPTH(16), .SEQ_W(8), .DROP_W(16)) bus ();
    tdc_result_fifo #(.DATA_W(16), .DEPTH(16), .SEQ_W(8), .DROP_W(16)) dut (
        .iClk(clk),
        .iRst(rst),
        .bus (bus.slave)
    );
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask
    task automatic model_clear();
        m_q.delete();
        m_head = '0;
        m_seq  = '0;
        m_drop = '0;
        m_ovf  = 1'b0;
        m_prev = 1'b0;
    endtask
    task automatic compare();
        check("valid", 32'(bus.oValid), 32'(m_q.size() != 0));
        check("level", 32'(bus.oLevel), 32'(m_q.size()));
        check("full", 32'(bus.oFull), 32'(m_q.size() == 16));
        check("dropcnt", 32'(bus.oDropCnt), 32'(m_drop));
        check("overflow", 32'(bus.oOverflow), 32'(m_ovf));
        check("data", 32'(bus.oData), 32'(m_head));
    endtask
    // Drive one cycle of inputs, advance the model by the spec rules, then compare.
    task automatic step(input logic done, input logic [15:0] tdc, input logic rdy, input logic clr);
        logic cap, pop, was_full;
        bus.iDone = done;
        bus.iTDC = tdc;
        bus.iReady = rdy;
        bus.iClrStat = clr;
        @(posedge clk);
        cap = done & ~m_prev;
        m_prev = done;
        was_full = m_q.size() == 16;
        pop = (m_q.size() != 0) && rdy;
        if (pop) void'(m_q.pop_front());
        if (clr) begin
            m_drop = '0;
            m_ovf = 1'b0;
        end
        if (cap) begin
            if (was_full) begin
                m_ovf = 1'b1;
                if (m_drop != 16'hffff) m_drop++;
            end else m_q.push_back({m_seq, tdc});
            m_seq++;
        end
        if (m_q.size() != 0) m_head = m_q[0];
        #1;
        compare();
    endtask
    task automatic pulse(input logic [15:0] tdc, input logic rdy);
        step(1'b1, tdc, rdy, 1'b0);
        step(1'b0, 16'(tdc + 16'h1111), rdy, 1'b0);
    endtask
    task automatic drain();
        for (int g = 0; g < 64 && m_q.size() != 0; g++) step(1'b0, 16'h0, 1'b1, 1'b0);
        check("drained", 32'(m_q.size()), 32'd0);
    endtask
    task automatic hard_reset();
        rst = 1'b1;
        #1;
        check("rst_valid", 32'(bus.oValid), 32'd0);
        check("rst_level", 32'(bus.oLevel), 32'd0);
        check("rst_drop", 32'(bus.oDropCnt), 32'd0);
        check("rst_ovf", 32'(bus.oOverflow), 32'd0);
        model_clear();
        @(negedge clk);
        rst = 1'b0;
    endtask
    initial begin
        bus.iDone = 1'b0;
        bus.iTDC = '0;
        bus.iReady = 1'b0;
        bus.iClrStat = 1'b0;
        model_clear();
        @(negedge clk);
        hard_reset();
        check("rst_data", 32'(bus.oData), 32'd0);
        check("rst_full", 32'(bus.oFull), 32'd0);
        // single capture, one-cycle latency to valid
        step(1'b1, 16'h0123, 1'b0, 1'b0);
        check("t1_data", 32'(bus.oData), 32'h000123);
        check("t1_level", 32'(bus.oLevel), 32'd1);
        step(1'b0, 16'h0, 1'b0, 1'b0);
        // long done pulse yields one entry
        for (int i = 0; i < 5; i++) step(1'b1, 16'($urandom), 1'b0, 1'b0);
        step(1'b0, 16'h0, 1'b0, 1'b0);
        check("t2_level", 32'(bus.oLevel), 32'd2);
        drain();
        pulse(16'h0055, 1'b0);
        check("t2_seq", 32'(bus.oData[23:16]), 32'd2);
        // 17 captures into 16 entries
        hard_reset();
        for (int i = 0; i < 17; i++) pulse(16'($urandom), 1'b0);
        check("t3_full", 32'(bus.oFull), 32'd1);
        check("t3_level", 32'(bus.oLevel), 32'd16);
        check("t3_drop", 32'(bus.oDropCnt), 32'd1);
        check("t3_ovf", 32'(bus.oOverflow), 32'd1);
        for (int i = 0; i < 16; i++) begin
            check("t3_tag", 32'(bus.oData[23:16]), 32'(i));
            step(1'b0, 16'h0, 1'b1, 1'b0);
        end
        pulse(16'h0abc, 1'b0);
        check("t3_next_tag", 32'(bus.oData[23:16]), 32'd17);
        // full with cap and pop together: dropped; then cap with clear
        for (int i = 0; i < 15; i++) pulse(16'($urandom), 1'b0);
        step(1'b1, 16'hbeef, 1'b1, 1'b0);
        check("t4_level", 32'(bus.oLevel), 32'd15);
        check("t4_drop", 32'(bus.oDropCnt), 32'd2);
        step(1'b0, 16'h0, 1'b0, 1'b0);
        pulse(16'h1234, 1'b0);
        step(1'b1, 16'h4321, 1'b0, 1'b1);
        check("t4_clr_drop", 32'(bus.oDropCnt), 32'd1);
        check("t4_clr_ovf", 32'(bus.oOverflow), 32'd1);
        step(1'b0, 16'h0, 1'b0, 1'b1);
        check("t4_clr_only", 32'(bus.oDropCnt), 32'd0);
        drain();
        // streaming with wrapping tags
        for (int i = 0; i < 300; i++) begin
            step(1'b1, 16'($urandom), 1'b1, 1'b0);
            step(1'b0, 16'($urandom), 1'b1, 1'b0);
            step(1'b0, 16'($urandom), 1'b1, 1'b0);
        end
        check("t5_nodrop", 32'(bus.oDropCnt), 32'd0);
        // random mix
        for (int i = 0; i < 600; i++)
            step(1'($urandom_range(0, 1)), 16'($urandom), 1'($urandom_range(0, 3) == 0),
                 1'($urandom_range(0, 40) == 0));
        // reset with entries stored
        drain();
        for (int i = 0; i < 5; i++) pulse(16'($urandom), 1'b0);
        check("t6_level_pre", 32'(bus.oLevel), 32'd5);
        #2;
        hard_reset();
        pulse(16'h0777, 1'b0);
        check("t6_tag", 32'(bus.oData), 32'h000777);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
